rotshift_counter: RTL
=====================

Name: rotshift_counter

Overview:
Parametrised loadable rotate/shift register with a step counter and a period-wrap pulse. It generalises the 4-bit load/rotate counter used in our stimulus benches: any width, left or right direction, and rotate, Johnson (twisted-ring) and serial-shift modes. It sits in test stimulus and sequencing paths as a one-hot/Johnson phase generator or a serial pattern shifter.

Parameters:
WIDTH, 4, register width; legal range is WIDTH >= 2.
RESET_VALUE, {{(WIDTH-1){1'b0}},1'b1}, value loaded into q on reset.
CW, $clog2(2*WIDTH+1), step_cnt width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous reset, active-low.
load  input  1  synchronous parallel load of data.
data  input  WIDTH  parallel load value.
en  input  1  advance one step this cycle.
dir  input  1  0 = left (toward MSB), 1 = right (toward LSB).
mode  input  2  00 rotate, 01 Johnson, 10 serial shift, 11 hold.
sin  input  1  serial input bit, used in shift mode only.
q  output  WIDTH  register state.
step_cnt  output  CW  steps taken in the current period.
wrap  output  1  one-cycle pulse when a period completes.

Behaviour:
- Reset (reset_n low, asynchronous): q = RESET_VALUE, step_cnt = 0, wrap = 0, last_mode = 00. Reset mid-operation takes effect immediately. The first step after reset_n rises occurs on the first clk edge that has en = 1.
- All outputs are registered. A step requested at edge N is visible after edge N.
- Priority: load > en. On load, q = data, step_cnt = 0, wrap = 0, and en is ignored that cycle.
- Step rules when en = 1:
  - Rotate, left: q = {q[W-2:0], q[W-1]}. Rotate, right: q = {q[0], q[W-1:1]}.
  - Johnson, left: q = {q[W-2:0], ~q[W-1]}. Johnson, right: q = {~q[0], q[W-1:1]}.
  - Shift, left: q = {q[W-2:0], sin}. Shift, right: q = {sin, q[W-1:1]}.
  - Hold (11): q, step_cnt and wrap are held at 0 pulse, and en is ignored.
- Period P: WIDTH in rotate and shift modes; 2*WIDTH in Johnson mode.
- Step count: each step increments step_cnt. On the step that makes the count reach P, step_cnt = 0 and wrap = 1 for exactly that cycle. Otherwise wrap = 0.
- Mode change: a registered last_mode is updated on every enabled step. If an enabled step has mode != last_mode, step_cnt restarts and that step counts as 1; no wrap is generated for the interrupted period.
- Direction change does not reset step_cnt.
- en = 0: q and step_cnt are held, and wrap = 0.
- dir and sin are sampled only on enabled steps.

Optional Feature:
Macro: ROTSHIFT_ONEHOT_CHECK_EN.
- Defined: adds output onehot_err (1 bit), reset to 0. It is set and held high (sticky) when mode = 00 and popcount(q) != 1 at any clock edge. It is cleared only by load of a value with popcount == 1, or by reset.
- Not defined: no onehot_err port and no check logic; all other behaviour is identical.

Test Plan:
1. Reset, WIDTH=4: hold reset_n = 0 for 3 clk -> q = 0001, step_cnt = 0, wrap = 0. Pulse reset_n low between edges -> q becomes 0001 immediately, without waiting for an edge.
2. Rotate left, en = 1 for 4 cycles from 0001 -> q = 0010, 0100, 1000, 0001. step_cnt = 1, 2, 3, 0. wrap is high only on the 4th step.
3. Johnson right, load 0000, then 8 steps -> q = 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000. wrap is high on the 8th step only.
4. load = 1 and en = 1 together with data = 1010 while step_cnt = 2 -> q = 1010, step_cnt = 0, wrap = 0, and no rotate that cycle.
5. Shift right, sin = 1, 4 steps from 0000 -> q = 1000, 1100, 1110, 1111, wrap on the 4th step. Then switch to rotate mid-period after 2 steps -> step_cnt restarts at 1, no wrap.
6. Feature defined: load 0011 in mode 00 -> onehot_err = 1 after the next edge. It stays high through further steps and clears after a load of 0100.

Source files
------------

// File: rtl/rotshift_counter.sv
// rtl/rotshift_counter.sv - loadable rotate/Johnson/shift register with step counter and period-wrap pulse
// Optional sticky one-hot checker enabled by macro ROTSHIFT_ONEHOT_CHECK_EN.
module rotshift_counter #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {{(WIDTH-1){1'b0}}, 1'b1},
    localparam int              CW          = $clog2(2*WIDTH+1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    step_cnt,
    output logic             wrap
`ifdef ROTSHIFT_ONEHOT_CHECK_EN
    ,
    output logic             onehot_err
`endif
);

    localparam logic [1:0] MODE_ROT  = 2'b00;
    localparam logic [1:0] MODE_JOHN = 2'b01;
    localparam logic [1:0] MODE_SHFT = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic [1:0]       last_mode_q, last_mode_d;
    logic [CW-1:0]    period;
    logic [CW-1:0]    cnt_inc;

    assign period  = (mode == MODE_JOHN) ? CW'(2*WIDTH) : CW'(WIDTH);
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        q_d         = q_q;
        cnt_d       = cnt_q;
        wrap_d      = 1'b0;
        last_mode_d = last_mode_q;
        if (load) begin
            q_d   = data;
            cnt_d = '0;
        end else if (en && (mode != MODE_HOLD)) begin
            case (mode)
                MODE_ROT:  q_d = dir ? {q_q[0], q_q[WIDTH-1:1]}  : {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_JOHN: q_d = dir ? {~q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
                default:   q_d = dir ? {sin, q_q[WIDTH-1:1]}     : {q_q[WIDTH-2:0], sin};
            endcase
            last_mode_d = mode;
            // A mode switch abandons the running period; this step opens a new one.
            if (mode != last_mode_q) begin
                cnt_d = CW'(1);
            end else if (cnt_inc == period) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q         <= RESET_VALUE;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
            last_mode_q <= MODE_ROT;
        end else begin
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            wrap_q      <= wrap_d;
            last_mode_q <= last_mode_d;
        end
    end

    assign q        = q_q;
    assign step_cnt = cnt_q;
    assign wrap     = wrap_q;

`ifdef ROTSHIFT_ONEHOT_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (load && ($countones(data) == 1)) begin
            err_d = 1'b0;
        end else if ((mode == MODE_ROT) && ($countones(q_q) != 1)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign onehot_err = err_q;
`endif

endmodule
